// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, FSM state type and channel helper
// for the pixel-sink block.
package vga_pkg;

  localparam int H_VIS       = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_TOT       = 800;
  localparam int V_VIS       = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_TOT       = 525;
  localparam int SCALE_SHIFT = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One colour bit drives a full 8-bit DAC channel.
  function automatic logic [7:0] expand_bit(input logic b);
    expand_bit = {8{b}};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one synchronous read port.
// A read of the address being written in the same clk returns the old contents.
module fb_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage array with registered read; no reset on the array by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel-plot sink: clears a 160x120x3 framebuffer, accepts plot writes and
// scans the buffer out as 640x480@60 VGA with 4x replication.
module vga_pixel_sink
  import vga_pkg::*;
#(
  parameter int         H_RES    = 160,
  parameter int         V_RES    = 120,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color,
  input  logic       plot,
  output logic       busy,
  output logic       drop,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int             FB_DEPTH  = H_RES * V_RES;
  localparam int             AW        = 15;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(FB_DEPTH - 1);
  localparam logic [AW-1:0]  H_RES_A   = AW'(H_RES);
  localparam logic [9:0]     H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0]     V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0]     H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0]     V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0]     HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0]     HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]     VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0]     VS_END    = 10'(V_VIS + V_FP + V_SYNC);

  state_t        state_r;
  logic [AW-1:0] clr_addr_r;
  logic          pix_en_r;
  logic [9:0]    h_r;
  logic [9:0]    v_r;
  logic          vis_d1_r;
  logic          hs_d1_r;
  logic          vs_d1_r;

  logic          x_ok_s;
  logic          y_ok_s;
  logic          plot_ok_s;
  logic [AW-1:0] wr_addr_s;
  logic [AW-1:0] rd_addr_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [2:0]    ram_wdata_s;
  logic [2:0]    pix_s;
  logic          vis_s;
  logic          hs_s;
  logic          vs_s;

  assign x_ok_s    = (32'(x) < 32'(H_RES));
  assign y_ok_s    = (32'(y) < 32'(V_RES));
  assign plot_ok_s = plot && x_ok_s && y_ok_s && (state_r == RUN) && !reset;
  assign wr_addr_s = AW'(y) * H_RES_A + AW'(x);

  // Single RAM write port: the clear sequencer owns it until RUN.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_addr_s;
    ram_wdata_s = color;
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_r;
      ram_wdata_s = BG_COLOR;
    end else begin
      ram_we_s    = plot_ok_s;
    end
  end

  // Clear sequencer and drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CLEAR;
      clr_addr_r <= 15'd0;
      busy       <= 1'b1;
      drop       <= 1'b0;
    end else begin
      drop <= plot && !plot_ok_s;
      case (state_r)
        CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_r    <= RUN;
            clr_addr_r <= 15'd0;
            busy       <= 1'b0;
          end else begin
            clr_addr_r <= clr_addr_r + 15'd1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          state_r <= RUN;
          busy    <= 1'b0;
        end
        default: begin
          state_r    <= CLEAR;
          clr_addr_r <= 15'd0;
          busy       <= 1'b1;
        end
      endcase
    end
  end

  // Pixel clock enable, raster counters and frame marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_r    <= 1'b0;
      h_r         <= 10'd0;
      v_r         <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      pix_en_r    <= ~pix_en_r;
      // Raised for the pix_en cycle that holds h=0,v=0.
      frame_start <= !pix_en_r && (h_r == 10'd0) && (v_r == 10'd0);
      if (pix_en_r) begin
        if (h_r == H_LAST) begin
          h_r <= 10'd0;
          if (v_r == V_LAST) begin
            v_r <= 10'd0;
          end else begin
            v_r <= v_r + 10'd1;
          end
        end else begin
          h_r <= h_r + 10'd1;
        end
      end
    end
  end

  assign vis_s = (h_r < H_VIS_C) && (v_r < V_VIS_C);
  assign hs_s  = !((h_r >= HS_BEG) && (h_r < HS_END));
  assign vs_s  = !((v_r >= VS_BEG) && (v_r < VS_END));

  // Read address; parked at 0 in blanking so it never leaves the array.
  always_comb begin
    rd_addr_s = 15'd0;
    if (vis_s) begin
      rd_addr_s = AW'(v_r >> SCALE_SHIFT) * H_RES_A + AW'(h_r >> SCALE_SHIFT);
    end else begin
      rd_addr_s = 15'd0;
    end
  end

  fb_ram #(
    .DEPTH (FB_DEPTH),
    .AW    (AW),
    .DW    (3)
  ) u_fb_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (rd_addr_s),
    .rdata (pix_s)
  );

  // Sync/blank delay line and output registers, aligned with RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_d1_r    <= 1'b0;
      hs_d1_r     <= 1'b1;
      vs_d1_r     <= 1'b1;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else begin
      vis_d1_r    <= vis_s;
      hs_d1_r     <= hs_s;
      vs_d1_r     <= vs_s;
      vga_hs      <= hs_d1_r;
      vga_vs      <= vs_d1_r;
      vga_blank_n <= vis_d1_r;
      if (vis_d1_r) begin
        vga_r <= expand_bit(pix_s[2]);
        vga_g <= expand_bit(pix_s[1]);
        vga_b <= expand_bit(pix_s[0]);
      end else begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end
    end
  end

endmodule

// File: doc/vga_pixel_sink.md
# vga_pixel_sink

Receiving end of the game's pixel-plot interface. It accepts the `x`/`y`/`color`/`plot` stream that the top-level datapath mux drives into a 160x120, 3-bit framebuffer. It scans that framebuffer out as 640x480@60 VGA with 4x pixel replication, and tells the game logic when a frame starts and whether a write was dropped. It sits between the game top and the board DAC pins.

## Interface
Parameters:
- `H_RES`, 160: framebuffer width in pixels.
- `V_RES`, 120: framebuffer height in pixels.
- `BG_COLOR`, 3'b000: colour written to every cell during the clear sequence.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: synchronous, active-high reset.
- `x` input 8: plot column.
- `y` input 8: plot row.
- `color` input 3: plot colour as {R,G,B}.
- `plot` input 1: write strobe. Each high cycle is one write.
- `busy` output 1: high while the clear sequence runs.
- `drop` output 1: one-cycle pulse when a plot write is discarded.
- `frame_start` output 1: one-cycle pulse when the scan enters line 0, column 0.
- `vga_hs` output 1: horizontal sync, active-low.
- `vga_vs` output 1: vertical sync, active-low.
- `vga_blank_n` output 1: high in the visible region.
- `vga_r` output 8: red channel.
- `vga_g` output 8: green channel.
- `vga_b` output 8: blue channel.

## Operation
- **States.** CLEAR and RUN.
  - Reset enters CLEAR with the clear address at 0.
  - CLEAR writes `BG_COLOR` to one address per clk, from 0 up to `H_RES*V_RES-1` (19199). It then moves to RUN.
  - `busy` is high exactly while in CLEAR.
  - Reset asserted at any point, including mid-clear, restarts CLEAR from address 0.
- **Write path.**
  - The address is `y*H_RES + x`, 15 bits wide.
  - The write is committed on the clk where `plot` is high, provided all of these hold: the block is in RUN, `x` < `H_RES`, and `y` < `V_RES`.
  - Any other `plot` cycle (in CLEAR, or with `x` or `y` out of range) is discarded, and `drop` pulses on the next clk.
  - No backpressure. One write per clk is always accepted in RUN.
- **Scan path.**
  - `pix_en` toggles every clk, giving 25 MHz.
  - The `h` counter (0..799) and `v` counter (0..524) advance only on `pix_en`.
  - `h` wraps 799→0 and then increments `v`; `v` wraps 524→0.
  - Visible region is `h`<640 and `v`<480.
  - Horizontal sync is low for `h` 656..751. Vertical sync is low for `v` 490..491.
  - Read address is `(v>>2)*H_RES + (h>>2)`.
  - Channel expansion: each colour bit is replicated ×8 onto its channel, so 1→8'hFF and 0→8'h00.
  - Outside the visible region the channels are 0.
  - The scan runs during CLEAR as well, and shows whatever the RAM currently holds.
- **Read/write collision** on the same address in the same clk: the read returns the old data.

## Timing
- **Reset values** (all outputs are registered):
  - `busy` = 1.
  - `drop` = 0 and `frame_start` = 0.
  - `vga_hs` = 1 and `vga_vs` = 1.
  - `vga_blank_n` = 0.
  - `vga_r`, `vga_g`, `vga_b` = 0.
  - Counters = 0 and `pix_en` = 0.
- **Write latency.** A pixel written at clk n is visible to a read issued at clk n+1.
- **Scan pipeline.**
  - Stage 0: counters.
  - Stage 1: RAM read (1 clk).
  - Stage 2: output registers.
  - Sync and blank are delayed 2 clk so they stay aligned with colour.
- **`frame_start`.** Pulses for 1 clk, on the pix_en cycle whose counters are h=0, v=0. It is coincident with that cycle's pixel, 2 clk before the pixel reaches the pins.
- **CLEAR duration.** Exactly 19200 clk. `busy` falls on clk 19200 after reset deasserts.
- **Drop with a valid write.** A drop and a valid write are never simultaneous, because there is a single write port.

## Structure
- Shared package `vga_pkg`, holding:
  - Constants: H_VIS 640, H_FP 16, H_SYNC 96, H_TOT 800, V_VIS 480, V_FP 10, V_SYNC 2, V_TOT 525, SCALE_SHIFT 2.
  - The state enum {CLEAR, RUN}.
- One sub-module, `fb_ram`: simple dual-port RAM with 1 write and 1 read port, depth `H_RES*V_RES`, width 3, synchronous read, read-old-on-collision. It is not reset.
- The top contains the clear FSM, the write-address computation, the scan counters and the output pipeline.

## Test plan
- Reset, then count cycles: `busy` stays high for 19200 clk and then drops. Reading every address returns 3'b000.
- Plot issued during CLEAR, with x=5, y=5, color 3'b111: `drop` pulses on the next clk, and cell (5,5) reads 0 after clear.
- In RUN, plot x=159, y=119, color 3'b101: the scan at h 636..639 and v 476..479 drives r=FF, g=00, b=FF with `vga_blank_n`=1.
- Plot with x=160, y=0, and separately x=0, y=120: `drop` pulses each time, and no framebuffer cell changes.
- Free-running scan: `vga_hs` is low for 96 pix_en periods out of every 800. `vga_vs` is low for 2 lines out of every 525. `frame_start` is spaced 420000 pix_en periods apart.
- Reset asserted at clear address 10000: `busy` stays high, and the clear restarts at 0 and takes a full 19200 clk.
